// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bundle: per-source completion requests in, single CDB broadcast out.
// Latency: none (wires only); timing is owned by the arbiter.
// Backpressure: in_req_ready per source, driven by the arbiter (slave) side.
interface cdb_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic [N_SRC-1:0]        in_req_valid;
  logic [N_SRC-1:0]        in_req_ready;
  logic [N_SRC*TAG_W-1:0]  in_req_tag;
  logic [N_SRC*DATA_W-1:0] in_req_val;
  logic [N_SRC*4-1:0]      in_req_icc;
  logic [N_SRC-1:0]        in_req_icc_wr;

  logic                    out_CDB_broadcast;
  logic [TAG_W-1:0]        out_CDB_tag;
  logic [DATA_W-1:0]       out_CDB_val;
  logic [3:0]              out_ICC_flags;
  logic                    out_ICC_wr;
  logic [2:0]              out_src_id;

  // Functional-unit side: produces completions, consumes the broadcast.
  modport master (
    output in_req_valid, in_req_tag, in_req_val, in_req_icc, in_req_icc_wr,
    input  in_req_ready,
    input  out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_flags, out_ICC_wr, out_src_id
  );

  // Arbiter side.
  modport slave (
    input  in_req_valid, in_req_tag, in_req_val, in_req_icc, in_req_icc_wr,
    output in_req_ready,
    output out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_flags, out_ICC_wr, out_src_id
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-source completion queues, one registered CDB grant per cycle.
// Latency: push into an empty, uncontended queue at edge k is broadcast after edge k+1.
// Backpressure: in_req_ready[i] low while queue i is full; CDB_ARB_RR_EN selects round-robin, else fixed priority.
module cdb_arbiter #(
  parameter int               N_SRC       = 4,
  parameter int               TAG_W       = 5,
  parameter int               DATA_W      = 32,
  parameter int               Q_DEPTH     = 2,
  parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(Q_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    logic [3:0]        icc;
    logic              icc_wr;
  } ent_t;

  ent_t             r_mem    [N_SRC][Q_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr [N_SRC];
  logic [PTR_W-1:0] r_wr_ptr [N_SRC];
  logic [CNT_W-1:0] r_cnt    [N_SRC];
`ifdef CDB_ARB_RR_EN
  logic [IDX_W-1:0] r_last;
`endif

  ent_t             w_in [N_SRC];
  ent_t             w_head;
  logic [N_SRC-1:0] w_ready;
  logic [N_SRC-1:0] w_nonempty;
  logic [N_SRC-1:0] w_push;
  logic [N_SRC-1:0] w_pop;
  logic             w_grant_vld;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_cand;

  assign bus.in_req_ready = w_ready;

  // Unpack per-source requests; ready reflects the current count only, never a same-cycle pop.
  always_comb begin
    w_ready    = '0;
    w_nonempty = '0;
    w_push     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_in[i] = {bus.in_req_tag[i*TAG_W +: TAG_W], bus.in_req_val[i*DATA_W +: DATA_W],
                 bus.in_req_icc[i*4 +: 4], bus.in_req_icc_wr[i]};
      w_ready[i]    = (r_cnt[i] != CNT_W'(Q_DEPTH));
      w_nonempty[i] = (r_cnt[i] != '0);
      // An invalid-tag completion handshakes normally but is never stored.
      w_push[i]     = bus.in_req_valid[i] && w_ready[i] && (w_in[i].tag != INVALID_TAG);
    end
  end

  // Pick the winning non-empty queue for this cycle.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
`ifdef CDB_ARB_RR_EN
    // Rotating search starting one past the last granted source.
    for (int k = 1; k <= N_SRC; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N_SRC);
      if (!w_grant_vld && w_nonempty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
`else
    // Lowest index always wins; high indices may starve.
    for (int k = 0; k < N_SRC; k++) begin
      w_cand = IDX_W'(k);
      if (!w_grant_vld && w_nonempty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
`endif
  end

  // Decode the grant into per-queue pops and fetch the winner's head entry.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_pop[i] = w_grant_vld && (w_grant_idx == IDX_W'(i));
    end
    w_head = r_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
  end

  // Queue control: wrap-around pointers and occupancy; reset drops everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Queue storage; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_in[i];
    end
  end

`ifdef CDB_ARB_RR_EN
  // Remember the last grant so the next search starts just past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDX_W'(N_SRC - 1);
    end else if (w_grant_vld) begin
      r_last <= w_grant_idx;
    end
  end
`endif

  // Registered CDB outputs: winner's head for one cycle, idle values otherwise.
  always_ff @(posedge clk) begin
    if (rst || !w_grant_vld) begin
      bus.out_CDB_broadcast <= 1'b0;
      bus.out_CDB_tag       <= INVALID_TAG;
      bus.out_CDB_val       <= '0;
      bus.out_ICC_flags     <= '0;
      bus.out_ICC_wr        <= 1'b0;
      bus.out_src_id        <= '0;
    end else begin
      bus.out_CDB_broadcast <= 1'b1;
      bus.out_CDB_tag       <= w_head.tag;
      bus.out_CDB_val       <= w_head.val;
      bus.out_ICC_flags     <= w_head.icc;
      bus.out_ICC_wr        <= w_head.icc_wr;
      bus.out_src_id        <= 3'(w_grant_idx);
    end
  end
endmodule
